// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator feeding a first-word-fall-through output FIFO with a sticky overflow flag.
// Optional macro FIR_DECIM_ROUND_EN selects round-half-up instead of truncation of the averaged sum.
module fir_decimator #(
   parameter int DATA_WIDTH = 10,
   parameter int DECIM      = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic signed [DATA_WIDTH-1:0]         in_data,
   input  logic                                 in_valid,
   output logic signed [DATA_WIDTH-1:0]         out_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
   output logic                                 overflow,
   input  logic                                 clr_ovf
);
   localparam int L  = $clog2(DECIM);
   localparam int AW = DATA_WIDTH + L;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;

   logic [L-1:0]                  phase;
   logic signed [AW-1:0]          acc;
   logic signed [AW-1:0]          base;
   logic signed [AW-1:0]          sum;
   logic signed [AW-1:0]          rsum;
   logic signed [DATA_WIDTH-1:0]  res;
   logic                          res_vld;

   assign base = (phase == '0) ? '0 : acc;
   assign sum  = base + AW'(in_data);

`ifdef FIR_DECIM_ROUND_EN
   localparam logic signed [AW-1:0] HALF = AW'(1) << (L - 1);
   assign rsum = sum + HALF;
`else
   assign rsum = sum;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         phase   <= '0;
         acc     <= '0;
         res     <= '0;
         res_vld <= 1'b0;
      end else begin
         res_vld <= 1'b0;
         if (in_valid) begin
            if (&phase) begin
               // Sum of DECIM samples divided by DECIM always fits the sample width.
               res     <= DATA_WIDTH'(rsum >>> L);
               res_vld <= 1'b1;
               phase   <= '0;
            end else begin
               acc   <= sum;
               phase <= phase + L'(1);
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [LW-1:0]         level;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  drop;

   assign full  = (level == LW'(FIFO_DEPTH));
   assign empty = (level == '0);
   assign pop   = !empty && out_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push  = res_vld && (!full || pop);
   assign drop  = res_vld && full && !pop;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   assign out_valid  = !empty;
   assign out_data   = empty ? '0 : mem[rd_ptr];
   assign fifo_level = level;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator (default parameters); expected values follow FIR_DECIM_ROUND_EN when defined.
module tb_fir_decimator;
   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [9:0]  in_data = '0;
   logic               in_valid = 1'b0;
   logic signed [9:0]  out_data;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [2:0]         fifo_level;
   logic               overflow;
   logic               clr_ovf = 1'b0;

   int checks = 0;
   int errors = 0;
   int pops = 0;
   logic signed [9:0] pq [$];

   fir_decimator #(.DATA_WIDTH(10), .DECIM(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_level(fifo_level), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) begin
         pops = pops + 1;
         pq.push_back(out_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_group(input logic signed [9:0] v);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = v;
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
      checks++; if (out_data !== 10'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      rst = 1'b0;
   endtask

   task automatic test_patterns();
      logic signed [9:0] s [4][4];
      logic signed [9:0] exp_v [4];
      s[0] = '{10'sd100, 10'sd101, 10'sd102, 10'sd103};
      s[1] = '{-10'sd1, -10'sd1, -10'sd1, -10'sd2};
      s[2] = '{10'sd511, 10'sd511, 10'sd511, 10'sd511};
      s[3] = '{-10'sd512, -10'sd512, -10'sd512, -10'sd512};
`ifdef FIR_DECIM_ROUND_EN
      exp_v = '{10'sd102, -10'sd1, 10'sd511, -10'sd512};
`else
      exp_v = '{10'sd101, -10'sd2, 10'sd511, -10'sd512};
`endif
      out_ready = 1'b1;
      for (int g = 0; g < 4; g++) begin
         for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = s[g][i];
            tick();
         end
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pat%0d_early_valid: got %b want 0", g, out_valid); end
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pat%0d_valid: got %b want 1", g, out_valid); end
         checks++; if (out_data !== exp_v[g]) begin errors++; $display("FAIL pat%0d_data: got %0d want %0d", g, out_data, exp_v[g]); end
         tick();
         checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL pat%0d_drained: level %0d want 0", g, fifo_level); end
      end
   endtask

   task automatic test_gapped();
      int p0;
      int early;
      p0 = pops;
      early = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1;
         in_data  = 10'sd8;
         tick();
         in_valid = 1'b0;
         if (out_valid) early++;
         tick();
         if (k == 3) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 10'sd8) begin
               errors++; $display("FAIL gapped_out: valid %b data %0d want 1/8", out_valid, out_data);
            end
         end else if (out_valid) early++;
         tick();
      end
      checks++; if (early !== 0) begin errors++; $display("FAIL gapped_early: %0d early valid cycles want 0", early); end
      tick();
      checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL gapped_count: %0d outputs want 1", pops - p0); end
   endtask

   task automatic test_overflow();
      int p0;
      out_ready = 1'b0;
      for (int g = 0; g < 4; g++) send_group(10'sd5);
      tick();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_fill_level: got %0d want 4", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b want 0", overflow); end
      for (int g = 4; g < 20; g++) send_group(10'sd5);
      tick();
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
      checks++; if (out_data !== 10'sd5) begin errors++; $display("FAIL ovf_held_data: got %0d want 5", out_data); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
      p0 = pops;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (pops - p0 !== 4) begin errors++; $display("FAIL ovf_drain_count: got %0d want 4", pops - p0); end
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d want 0", fifo_level); end
   endtask

   task automatic test_back_to_back();
      logic signed [9:0] exp_v [5];
      exp_v = '{10'sd10, 10'sd20, 10'sd30, 10'sd40, 10'sd50};
      out_ready = 1'b0;
      for (int g = 0; g < 4; g++) send_group(exp_v[g]);
      send_group(10'sd50);
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_full: level %0d want 4", fifo_level); end
      pq.delete();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d want 4", fifo_level); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
      checks++; if (out_data !== 10'sd20) begin errors++; $display("FAIL b2b_head: got %0d want 20", out_data); end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      checks++; if (pq.size() !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", pq.size()); end
      for (int i = 0; i < 5; i++) begin
         if (i < pq.size()) begin
            checks++; if (pq[i] !== exp_v[i]) begin errors++; $display("FAIL b2b_order%0d: got %0d want %0d", i, pq[i], exp_v[i]); end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_data  = 10'sd77;
      tick();
      tick();
      rst = 1'b1;
      in_data = 10'sd99;
      clr_ovf = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      clr_ovf = 1'b0;
      checks++; if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rstmid_clear: level %0d valid %b want 0/0", fifo_level, out_valid);
      end
      p0 = pops;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = 10'sd40;
         tick();
         if (i == 1 && out_valid !== 1'b0) begin
            checks++; errors++; $display("FAIL rstmid_residue: out_valid %b after 2 samples want 0", out_valid);
         end
      end
      in_valid = 1'b0;
      checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_level0: got %0d want 0", fifo_level); end
      tick();
      checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL rstmid_level1: got %0d want 1", fifo_level); end
      checks++; if (out_data !== 10'sd40) begin errors++; $display("FAIL rstmid_data: got %0d want 40", out_data); end
      tick();
      tick();
      checks++; if (pops - p0 !== 1) begin errors++; $display("FAIL rstmid_count: got %0d want 1", pops - p0); end
   endtask

   initial begin
      test_reset();
      test_patterns();
      test_gapped();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameter DATA_WIDTH, default 10: signed sample width, input and output.
REQ-002 Parameter DECIM, default 4: decimation factor; power of two, at least 2.
REQ-003 Parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-004 clk  input  1: single clock, all logic on rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH signed: filtered sample from the FIR stage.
REQ-007 in_valid  input  1: in_data is valid this cycle; no backpressure toward the FIR stage.
REQ-008 out_data  output  DATA_WIDTH signed: decimated sample at the FIFO head.
REQ-009 out_valid  output  1: FIFO not empty.
REQ-010 out_ready  input  1: consumer accepts out_data when out_valid && out_ready.
REQ-011 fifo_level  output  $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-012 overflow  output  1: sticky flag, set when a result is dropped.
REQ-013 clr_ovf  input  1: clears overflow.

Function
REQ-014 Integrate-and-dump: a phase counter 0..DECIM-1 advances on each in_valid cycle; cycles without in_valid leave accumulator and phase unchanged.
REQ-015 Accumulator width is DATA_WIDTH+L, where L=$clog2(DECIM); at phase 0 it loads in_data sign-extended, otherwise it adds in_data.
REQ-016 On the in_valid cycle with phase==DECIM-1, the full sum (including that sample) is formed, result = sum >>> L (arithmetic), and the phase wraps to 0.
REQ-017 The result is registered and pushed into the FIFO on the next rising edge; with the FIFO previously empty, out_valid asserts 1 cycle after the last contributing sample's edge.
REQ-018 The result always fits DATA_WIDTH; no saturation logic is required.
REQ-019 FIFO is first-word-fall-through: out_data shows the head entry whenever out_valid=1, and out_data is held stable while out_valid && !out_ready.
REQ-020 A pop occurs on a cycle with out_valid && out_ready; fifo_level tracks the net of pushes and pops each cycle.
REQ-021 A simultaneous push and pop while full is accepted; the level stays FIFO_DEPTH and there is no overflow.
REQ-022 A push while full without a pop drops the new result, leaves FIFO contents unchanged, and sets overflow on the next edge.
REQ-023 A simultaneous push and pop while empty: the pop is ignored (out_valid=0), the push lands, and the level becomes 1.
REQ-024 clr_ovf clears overflow on the next edge; if a drop happens in the same cycle, set wins.
REQ-025 Read and write pointers wrap modulo FIFO_DEPTH; full is level==FIFO_DEPTH and empty is level==0.

Reset
REQ-026 While rst=1 at a clock edge: phase=0, accumulator=0, pending result cleared, pointers=0, fifo_level=0, out_valid=0, out_data=0, overflow=0.
REQ-027 Reset mid-accumulation discards the partial sum; the first in_valid after reset release is phase 0.
REQ-028 Reset overrides in_valid, out_ready and clr_ovf in the same cycle.

Configuration
REQ-029 Macro FIR_DECIM_ROUND_EN: when defined, result = (sum + 2^(L-1)) >>> L, i.e. round half up, computed in DATA_WIDTH+L bits (max 511*4+2 fits for defaults).
REQ-030 Without FIR_DECIM_ROUND_EN, result = sum >>> L (truncation toward negative infinity).

Verification
REQ-031 DECIM=4, samples 100,101,102,103 on consecutive cycles, out_ready=1 -> out_data=101 (no macro) or 102 (macro); out_valid asserts 1 cycle after the sample-103 edge.
REQ-032 Samples -1,-1,-1,-2 -> out_data=-2 (no macro) or -1 (macro); samples 511 x4 -> 511; samples -512 x4 -> -512.
REQ-033 in_valid gapped (1 of every 3 cycles), samples 8,8,8,8 -> exactly one output of 8; no output before the 4th valid sample.
REQ-034 out_ready=0, 20 groups of 4 samples of value 5 -> fifo_level reaches 4, out_data=5 held, overflow=1 after the 5th result; clr_ovf pulse -> overflow=0; out_ready=1 -> exactly 4 outputs drain.
REQ-035 FIFO full with a push and pop in the same cycle -> level stays 4, overflow stays 0, entries emerge in order.
REQ-036 rst=1 after 2 samples of a group, then samples 40,40,40,40 -> single output 40, level 0 to 1, no residue from the pre-reset partial sum.
